// File: rtl/gpio_debounce_pkg.sv
// ---------------------------------------------------------------------------
// gpio_debounce_pkg
// Shared constants for the GPIO debouncer: register address map.
// ---------------------------------------------------------------------------
package gpio_debounce_pkg;

  localparam logic [1:0] DB_CTRL   = 2'd0;  // bit0: enable
  localparam logic [1:0] DB_PERIOD = 2'd1;  // debounce threshold, cnt_w bits
  localparam logic [1:0] DB_RAW    = 2'd2;  // synchronized pins, read-only
  localparam logic [1:0] DB_STATE  = 2'd3;  // debounced lines, read-only

endpackage

// File: rtl/gpio_debounce_db_cell.sv
// ---------------------------------------------------------------------------
// db_cell
// One debounced input line: 2-FF synchronizer, stability counter, debounced
// state flop and registered rise/fall pulses.
// Ports:
//   clk      - clock
//   rstn     - asynchronous active-low reset
//   i_pin    - raw asynchronous pin
//   i_en     - 1: debounce with i_period, 0: pass synchronized pin through
//   i_period - number of extra stable cycles required before accepting
//   o_sync   - synchronized pin (second synchronizer stage)
//   o_db     - debounced level
//   o_rise   - one-cycle pulse coincident with o_db going 0->1
//   o_fall   - one-cycle pulse coincident with o_db going 1->0
// ---------------------------------------------------------------------------
module db_cell #(
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_pin,
  input  logic             i_en,
  input  logic [cnt_w-1:0] i_period,
  output logic             o_sync,
  output logic             o_db,
  output logic             o_rise,
  output logic             o_fall
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic [cnt_w-1:0] r_cnt;

  logic             w_db_next;
  logic [cnt_w-1:0] w_cnt_next;

  // The counter only advances while the synchronized level differs from the
  // accepted level. The >= comparison means a threshold lowered below the
  // running count is honoured on the very next edge, and since we never
  // increment at or past the threshold the counter cannot wrap.
  always_comb begin
    w_db_next  = r_db;
    w_cnt_next = '0;
    if (!i_en) begin
      w_db_next = r_sync2;
    end else if (r_sync2 != r_db) begin
      if (r_cnt >= i_period) begin
        w_db_next = r_sync2;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_db    <= w_db_next;
      // Pulses are computed from the next state so they line up with the
      // cycle in which o_db first shows the new value.
      r_rise  <= w_db_next & ~r_db;
      r_fall  <= ~w_db_next & r_db;
      r_cnt   <= w_cnt_next;
    end
  end

  assign o_sync = r_sync2;
  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/reg_we.sv
// ---------------------------------------------------------------------------
// reg_we
// Generic write-enabled register with a parameterized reset value.
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset (loads RST_VAL)
//   we   - load enable
//   d    - data to load
//   q    - register contents
// ---------------------------------------------------------------------------
module reg_we #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= RST_VAL;
    end else if (we) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/gpio_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce
// Multi-line debouncer for keys/switches with a small register interface.
// Ports:
//   clk    - clock
//   rstn   - asynchronous active-low reset
//   addr   - register address (see gpio_debounce_pkg)
//   we     - write enable, write lands on the rising edge
//   wd     - write data
//   rd     - read data, combinational from addr, zero-extended
//   pin_i  - raw asynchronous pins
//   db_o   - debounced lines
//   rise_o - per-line pulse on debounced 0->1
//   fall_o - per-line pulse on debounced 1->0
// ---------------------------------------------------------------------------
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int gpio_w     = 8,
  parameter int cnt_w      = 16,
  parameter int period_rst = 50000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  input  logic [gpio_w-1:0] pin_i,
  output logic [gpio_w-1:0] db_o,
  output logic [gpio_w-1:0] rise_o,
  output logic [gpio_w-1:0] fall_o
);

  localparam logic [cnt_w-1:0] PERIOD_RST_V = cnt_w'(period_rst);

  logic              w_ctrl_we;
  logic              w_period_we;
  logic              w_en;
  logic [cnt_w-1:0]  w_period;
  logic [gpio_w-1:0] w_raw;
  logic [gpio_w-1:0] w_db;
  logic [gpio_w-1:0] w_rise;
  logic [gpio_w-1:0] w_fall;
  // Upper write-data bits have no home in this register map.
  logic              w_unused_wd;

  assign w_ctrl_we   = we && (addr == DB_CTRL);
  assign w_period_we = we && (addr == DB_PERIOD);
  assign w_unused_wd = &{1'b0, wd};

  reg_we #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_ctrl (
    .clk  (clk),
    .rstn (rstn),
    .we   (w_ctrl_we),
    .d    (wd[0]),
    .q    (w_en)
  );

  reg_we #(
    .W       (cnt_w),
    .RST_VAL (PERIOD_RST_V)
  ) u_period (
    .clk  (clk),
    .rstn (rstn),
    .we   (w_period_we),
    .d    (wd[cnt_w-1:0]),
    .q    (w_period)
  );

  generate
    for (genvar gi = 0; gi < gpio_w; gi++) begin : g_cell
      db_cell #(
        .cnt_w (cnt_w)
      ) u_cell (
        .clk      (clk),
        .rstn     (rstn),
        .i_pin    (pin_i[gi]),
        .i_en     (w_en),
        .i_period (w_period),
        .o_sync   (w_raw[gi]),
        .o_db     (w_db[gi]),
        .o_rise   (w_rise[gi]),
        .o_fall   (w_fall[gi])
      );
    end
  endgenerate

  always_comb begin
    rd = '0;
    case (addr)
      DB_CTRL:   rd = {31'd0, w_en};
      DB_PERIOD: rd = 32'(w_period);
      DB_RAW:    rd = 32'(w_raw);
      DB_STATE:  rd = 32'(w_db);
      default:   rd = '0;
    endcase
  end

  assign db_o   = w_db;
  assign rise_o = w_rise;
  assign fall_o = w_fall;

endmodule

// File: tb/tb_gpio_debounce.sv
module tb_gpio_debounce;

  localparam int GW = 8;
  localparam int CW = 16;
  localparam int PR = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    addr;
  logic          we;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic [GW-1:0] pin_i;
  logic [GW-1:0] db_o;
  logic [GW-1:0] rise_o;
  logic [GW-1:0] fall_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_debounce #(
    .gpio_w     (GW),
    .cnt_w      (CW),
    .period_rst (PR)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .addr   (addr),
    .we     (we),
    .wd     (wd),
    .rd     (rd),
    .pin_i  (pin_i),
    .db_o   (db_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    we   = 1'b1;
    wd   = d;
    tick();
    we   = 1'b0;
    wd   = '0;
  endtask

  logic p_hist [0:11];

  initial begin
    rstn  = 1'b0;
    addr  = 2'd0;
    we    = 1'b0;
    wd    = '0;
    pin_i = '0;

    // ---------------- reset state ----------------
    #1;
    check("rst_db", 32'(db_o), 32'h0);
    check("rst_rise", 32'(rise_o), 32'h0);
    check("rst_fall", 32'(fall_o), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // ---------------- register map table ----------------
    vecs[0] = '{"rd_ctrl_rst",   1'b0, 2'd0, 32'h0,        32'h1};
    vecs[1] = '{"rd_period_rst", 1'b0, 2'd1, 32'h0,        32'(PR)};
    vecs[2] = '{"rd_raw_rst",    1'b0, 2'd2, 32'h0,        32'h0};
    vecs[3] = '{"rd_state_rst",  1'b0, 2'd3, 32'h0,        32'h0};
    vecs[4] = '{"wr_period_trunc", 1'b1, 2'd1, 32'h0001_2345, 32'h2345};
    vecs[5] = '{"wr_ctrl_off",   1'b1, 2'd0, 32'hFFFF_FFFE, 32'h0};
    vecs[6] = '{"wr_ctrl_on",    1'b1, 2'd0, 32'h0000_0001, 32'h1};
    vecs[7] = '{"wr_raw_ign",    1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
    vecs[8] = '{"wr_state_ign",  1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[9] = '{"wr_period_4",   1'b1, 2'd1, 32'h0000_0004, 32'h4};

    for (int i = 0; i < 10; i++) begin
      addr = vecs[i].addr;
      we   = vecs[i].we;
      wd   = vecs[i].wd;
      tick();
      we   = 1'b0;
      wd   = '0;
      #1;
      check(vecs[i].name, rd, vecs[i].exp);
    end

    // ---------------- A: clean rise/fall, period 4 ----------------
    pin_i[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("A_db_k%0d", k), 32'(db_o[0]), 32'(k >= 6));
      check($sformatf("A_rise_k%0d", k), 32'(rise_o), (k == 6) ? 32'h1 : 32'h0);
    end
    pin_i[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("A_fall_k%0d", k), 32'(fall_o), (k == 6) ? 32'h1 : 32'h0);
    end

    // ---------------- B: bounce restarts the count ----------------
    pin_i[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("B_hi_norise", 32'(rise_o), 32'h0);
    end
    pin_i[0] = 1'b0;
    tick();
    check("B_lo_norise", 32'(rise_o), 32'h0);
    pin_i[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("B_db_k%0d", k), 32'(db_o[0]), 32'(k >= 6));
      check($sformatf("B_rise_k%0d", k), 32'(rise_o), (k == 6) ? 32'h1 : 32'h0);
    end
    pin_i[0] = 1'b0;
    repeat (10) tick();
    check("B_settled", 32'(db_o), 32'h0);

    // ---------------- C: bypass mode, pin1 toggles ----------------
    wr(2'd0, 32'h0);
    for (int n = 0; n < 12; n++) begin
      p_hist[n] = (n % 2 == 0);
      pin_i[1]  = p_hist[n];
      tick();
      if (n >= 3) begin
        check($sformatf("C_db_n%0d", n), 32'(db_o[1]), 32'(p_hist[n-2]));
        check($sformatf("C_rise_n%0d", n), 32'(rise_o[1]), 32'(p_hist[n-2] & ~p_hist[n-3]));
        check($sformatf("C_fall_n%0d", n), 32'(fall_o[1]), 32'(~p_hist[n-2] & p_hist[n-3]));
      end
    end
    pin_i[1] = 1'b0;
    repeat (4) tick();
    wr(2'd0, 32'h1);
    check("C_settled", 32'(db_o), 32'h0);

    // ---------------- D: period lowered below running count ----------------
    wr(2'd1, 32'd100);
    pin_i[2] = 1'b1;
    for (int k = 0; k < 52; k++) begin
      tick();
      check("D_norise", 32'(rise_o), 32'h0);
    end
    addr = 2'd1;
    we   = 1'b1;
    wd   = 32'd10;
    tick();
    we   = 1'b0;
    wd   = '0;
    check("D_wr_db", 32'(db_o), 32'h0);
    check("D_wr_rise", 32'(rise_o), 32'h0);
    check("D_period_rd", rd, 32'd10);
    tick();
    check("D_next_db", 32'(db_o), 32'h04);
    check("D_next_rise", 32'(rise_o), 32'h04);
    tick();
    check("D_after_rise", 32'(rise_o), 32'h0);
    check("D_after_db", 32'(db_o), 32'h04);
    pin_i[2] = 1'b0;
    repeat (14) tick();
    check("D_settled", 32'(db_o), 32'h0);

    // ---------------- E: reset mid-count ----------------
    pin_i = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("E_norise", 32'(rise_o), 32'h0);
    end
    rstn = 1'b0;
    addr = 2'd1;
    #1;
    check("E_rst_db", 32'(db_o), 32'h0);
    check("E_rst_rise", 32'(rise_o), 32'h0);
    check("E_rst_period", rd, 32'(PR));
    tick();
    tick();
    check("E_rst_hold_db", 32'(db_o), 32'h0);
    check("E_rst_hold_rise", 32'(rise_o), 32'h0);
    check("E_rst_hold_fall", 32'(fall_o), 32'h0);
    rstn = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("E_rise_k%0d", k), 32'(rise_o), (k == 7) ? 32'hFF : 32'h0);
      check($sformatf("E_db_k%0d", k), 32'(db_o), (k >= 7) ? 32'hFF : 32'h0);
    end
    addr = 2'd1;
    #1;
    check("E_period_rd", rd, 32'(PR));
    addr = 2'd3;
    #1;
    check("E_state_rd", rd, 32'hFF);
    addr = 2'd2;
    #1;
    check("E_raw_rd", rd, 32'hFF);
    addr = 2'd0;
    #1;
    check("E_ctrl_rd", rd, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
